// File: rtl/mul_share_ctrl.sv
// rtl/mul_share_ctrl.sv - round-robin sharing of one pipelined 8x8 multiplier core
module mul_share_ctrl #(
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*8-1:0] req_a,
  input  logic [NREQ*8-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic [7:0]        mul_multiplicand,
  output logic [7:0]        mul_multiplier,
  input  logic [15:0]       mul_product,
  output logic              res_valid,
  output logic [IDW-1:0]    res_id,
  output logic [15:0]       res_product,
  input  logic              flush,
  output logic              busy,
  output logic              flush_done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t              state;
  state_t              state_next;
  logic                done_next;
  logic [IDW-1:0]      ptr;
  logic [IDW-1:0]      cand;
  logic [IDW-1:0]      grant_idx;
  logic                grant_any;
  logic [NREQ-1:0]     grant_onehot;
  logic [7:0]          sel_a;
  logic [7:0]          sel_b;
  logic                transfer;
  logic [LATENCY:0]    tag_v;
  logic [IDW-1:0]      tag_id [LATENCY+1];
  logic                pipe_empty;

  // Round-robin search: first valid requester after the last granted one.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IDW'((int'(ptr) + k) % NREQ);
      if (!grant_any && req_valid[cand]) begin
        grant_any = 1'b1;
        grant_idx = cand;
      end
    end
  end

  // Decode the winner into a one-hot grant and pick its operand slices.
  always_comb begin
    grant_onehot = '0;
    sel_a        = '0;
    sel_b        = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_idx == IDW'(i)) begin
        grant_onehot[i] = grant_any;
        sel_a           = req_a[8*i +: 8];
        sel_b           = req_b[8*i +: 8];
      end
    end
  end

  // flush blocks acceptance in the same cycle, so a flush never races a transfer.
  assign req_ready  = (state != DRAIN && !flush && !rst) ? grant_onehot : '0;
  assign transfer   = |(req_valid & req_ready);
  assign pipe_empty = ~|tag_v;
  assign busy       = (state != IDLE) || !pipe_empty;

  // Operand registers, RR pointer, tag pipe tracking the core, and result capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr              <= IDW'(NREQ - 1);
      mul_multiplicand <= '0;
      mul_multiplier   <= '0;
      tag_v            <= '0;
      for (int i = 0; i <= LATENCY; i++) tag_id[i] <= '0;
      res_valid        <= 1'b0;
      res_id           <= '0;
      res_product      <= '0;
    end else begin
      if (transfer) begin
        ptr              <= grant_idx;
        mul_multiplicand <= sel_a;
        mul_multiplier   <= sel_b;
      end
      tag_v     <= {tag_v[LATENCY-1:0], transfer};
      tag_id[0] <= transfer ? grant_idx : '0;
      for (int i = 1; i <= LATENCY; i++) tag_id[i] <= tag_id[i-1];
      res_valid <= tag_v[LATENCY];
      if (tag_v[LATENCY]) begin
        res_id      <= tag_id[LATENCY];
        res_product <= mul_product;
      end
    end
  end

  // State register plus the registered flush_done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      flush_done <= 1'b0;
    end else begin
      state      <= state_next;
      flush_done <= done_next;
    end
  end

  // Next-state: DRAIN waits until the last tag has left the pipe (its result is on the outputs).
  always_comb begin
    state_next = state;
    done_next  = 1'b0;
    case (state)
      IDLE: begin
        if (transfer) begin
          state_next = RUN;
        end else if (flush) begin
          done_next = 1'b1;
        end
      end
      RUN: begin
        if (flush) begin
          state_next = DRAIN;
        end else if (req_valid == '0 && pipe_empty) begin
          state_next = IDLE;
        end
      end
      DRAIN: begin
        if (pipe_empty) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule
